// File: rtl/onoff_pkg.sv
// onoff_pkg: shared ON/OFF state encoding, sequencer FSM states and default widths
package onoff_pkg;
    typedef enum logic {ON = 1'b0, OFF = 1'b1} onoff_t;
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} seq_state_t;
    localparam int CNT_W_DEF = 16;
    localparam int REP_W_DEF = 8;
endpackage

// File: rtl/onoff_state_sequencer_phase_timer.sv
// phase_timer: loadable down-counter flagging the last cycle of a dwell phase
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign expired = cnt_q == '0;
endmodule

// File: rtl/onoff_state_sequencer.sv
// onoff_state_sequencer: programmable ON/OFF dwell sequencer with phase-change and completion strobes
module onoff_state_sequencer
    import onoff_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] on_len,
    input  logic [CNT_W-1:0] off_len,
    input  logic [REP_W-1:0] repeat_cnt,
    output onoff_t           state_o,
    output logic             busy,
    output logic             state_chg,
    output logic             done,
    output logic [REP_W-1:0] periods_done
);
    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] on_q, on_d, off_q, off_d, tmr_val;
    logic [REP_W-1:0] rep_q, rep_d, periods_q, periods_d, periods_inc;
    onoff_t           state_o_q, state_o_d;
    logic             busy_q, busy_d, chg_q, chg_d, done_q, done_d;
    logic             tmr_load, expired, start_ok, period_end, finish;

    // A zero length still dwells one cycle, so the timer loads max(len,1)-1
    function automatic logic [CNT_W-1:0] dwell(input logic [CNT_W-1:0] len);
        return len == '0 ? '0 : len - 1'b1;
    endfunction

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (state_q != S_IDLE),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            on_q      <= '0;
            off_q     <= '0;
            rep_q     <= '0;
            periods_q <= '0;
            state_o_q <= OFF;
            busy_q    <= 1'b0;
            chg_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            on_q      <= on_d;
            off_q     <= off_d;
            rep_q     <= rep_d;
            periods_q <= periods_d;
            state_o_q <= state_o_d;
            busy_q    <= busy_d;
            chg_q     <= chg_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        start_ok    = state_q == S_IDLE && start && !stop;
        periods_inc = &periods_q ? periods_q : periods_q + 1'b1;
        period_end  = state_q == S_OFF && expired && !stop;
        finish      = period_end && rep_q != '0 && periods_inc == rep_q;
        state_d     = state_q;
        on_d        = on_q;
        off_d       = off_q;
        rep_d       = rep_q;
        tmr_load    = 1'b0;
        tmr_val     = dwell(on_q);
        if (stop) begin
            state_d = S_IDLE;
        end else if (start_ok) begin
            state_d  = S_ON;
            on_d     = on_len;
            off_d    = off_len;
            rep_d    = repeat_cnt;
            tmr_load = 1'b1;
            tmr_val  = dwell(on_len);
        end else if (state_q == S_ON && expired) begin
            state_d  = S_OFF;
            tmr_load = 1'b1;
            tmr_val  = dwell(off_q);
        end else if (period_end) begin
            state_d  = finish ? S_IDLE : S_ON;
            tmr_load = !finish;
        end
    end

    // Leaving to IDLE only counts as a change when the visible state drops from ON
    always_comb begin
        state_o_d = state_d == S_ON ? ON : OFF;
        busy_d    = state_d != S_IDLE;
        chg_d     = state_d != state_q && (state_d != S_IDLE || state_q == S_ON);
        done_d    = finish;
        periods_d = start_ok ? '0 : period_end ? periods_inc : periods_q;
    end

    assign state_o      = state_o_q;
    assign busy         = busy_q;
    assign state_chg    = chg_q;
    assign done         = done_q;
    assign periods_done = periods_q;
endmodule

// File: tb/tb_onoff_state_sequencer.sv
// tb_onoff_state_sequencer: directed checks of the ON/OFF sequencer against hand-computed cycle tables
module tb_onoff_state_sequencer;
    import onoff_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b0, start = 1'b0, stop = 1'b0;
    logic [15:0] on_len = '0, off_len = '0;
    logic [7:0]  repeat_cnt = '0;
    onoff_t      state_o;
    logic        busy, state_chg, done;
    logic [7:0]  periods_done;
    int          n_vec = 0, n_bad = 0;

    onoff_state_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .on_len       (on_len),
        .off_len      (off_len),
        .repeat_cnt   (repeat_cnt),
        .state_o      (state_o),
        .busy         (busy),
        .state_chg    (state_chg),
        .done         (done),
        .periods_done (periods_done)
    );

    always #5 clk = ~clk;

    // Observed vector is {state_o, busy, state_chg, done}; state_o bit is 0 for ON
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] on_v, input logic [15:0] off_v, input logic [7:0] rep_v);
        on_len = on_v;
        off_len = off_v;
        repeat_cnt = rep_v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_vec++;
        if ({state_o, busy, state_chg, done} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected %b", {state_o, busy, state_chg, done}, 4'b1000);
        end
        n_vec++;
        if (periods_done !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_periods: got %0d expected 0", periods_done);
        end
    endtask

    task automatic test_two_periods();
        logic [3:0] e;
        go(16'd3, 16'd2, 8'd2);
        for (int c = 1; c <= 11; c++) begin
            e = {!((c <= 3) || (c >= 6 && c <= 8)), c <= 10, c == 1 || c == 4 || c == 6 || c == 9, c == 11};
            n_vec++;
            if ({state_o, busy, state_chg, done} !== e) begin
                n_bad++;
                $display("FAIL two_periods cycle %0d: got %b expected %b", c, {state_o, busy, state_chg, done}, e);
            end
            if (c == 6 || c == 11) begin
                n_vec++;
                if (periods_done !== (c == 6 ? 8'd1 : 8'd2)) begin
                    n_bad++;
                    $display("FAIL two_periods_count cycle %0d: got %0d expected %0d", c, periods_done, c == 6 ? 1 : 2);
                end
            end
            tick();
        end
    endtask

    task automatic test_zero_len();
        logic [3:0] e [3];
        e = '{4'b0110, 4'b1110, 4'b1001};
        go(16'd0, 16'd0, 8'd1);
        for (int c = 1; c <= 3; c++) begin
            n_vec++;
            if ({state_o, busy, state_chg, done} !== e[c-1]) begin
                n_bad++;
                $display("FAIL zero_len cycle %0d: got %b expected %b", c, {state_o, busy, state_chg, done}, e[c-1]);
            end
            if (c < 3) tick();
        end
        n_vec++;
        if (periods_done !== 8'd1) begin
            n_bad++;
            $display("FAIL zero_len_count: got %0d expected 1", periods_done);
        end
        tick();
    endtask

    task automatic test_infinite();
        logic [3:0] e;
        go(16'd1, 16'd1, 8'd0);
        for (int c = 1; c <= 600; c++) begin
            e = {c % 2 == 0, 1'b1, 1'b1, 1'b0};
            n_vec++;
            if ({state_o, busy, state_chg, done} !== e) begin
                n_bad++;
                $display("FAIL infinite cycle %0d: got %b expected %b", c, {state_o, busy, state_chg, done}, e);
            end
            if (c < 600) tick();
        end
        n_vec++;
        if (periods_done !== 8'd255) begin
            n_bad++;
            $display("FAIL infinite_saturate: got %0d expected 255", periods_done);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_vec++;
        if ({state_o, busy, state_chg, done, periods_done} !== {4'b1000, 8'd255}) begin
            n_bad++;
            $display("FAIL infinite_stop: got %b/%0d expected 1000/255", {state_o, busy, state_chg, done}, periods_done);
        end
    endtask

    task automatic test_start_ignored();
        logic [3:0] e [5];
        e = '{4'b0110, 4'b0100, 4'b1110, 4'b1100, 4'b1001};
        go(16'd2, 16'd2, 8'd1);
        for (int c = 1; c <= 5; c++) begin
            n_vec++;
            if ({state_o, busy, state_chg, done} !== e[c-1]) begin
                n_bad++;
                $display("FAIL start_ignored cycle %0d: got %b expected %b", c, {state_o, busy, state_chg, done}, e[c-1]);
            end
            if (c == 1) begin
                on_len = 16'd1;
                off_len = 16'd1;
                repeat_cnt = 8'd3;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_stop();
        go(16'd4, 16'd4, 8'd3);
        n_vec++;
        if ({state_o, busy, state_chg, done} !== 4'b0110) begin
            n_bad++;
            $display("FAIL stop_c1: got %b expected 0110", {state_o, busy, state_chg, done});
        end
        tick();
        n_vec++;
        if ({state_o, busy, state_chg, done} !== 4'b0100) begin
            n_bad++;
            $display("FAIL stop_c2: got %b expected 0100", {state_o, busy, state_chg, done});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_vec++;
        if ({state_o, busy, state_chg, done, periods_done} !== {4'b1010, 8'd0}) begin
            n_bad++;
            $display("FAIL stop_abort: got %b/%0d expected 1010/0", {state_o, busy, state_chg, done}, periods_done);
        end
        tick();
        n_vec++;
        if ({state_o, busy, state_chg, done} !== 4'b1000) begin
            n_bad++;
            $display("FAIL stop_settle: got %b expected 1000", {state_o, busy, state_chg, done});
        end
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        n_vec++;
        if ({state_o, busy, state_chg, done} !== 4'b1000) begin
            n_bad++;
            $display("FAIL stop_beats_start: got %b expected 1000", {state_o, busy, state_chg, done});
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e [4];
        e = '{4'b0110, 4'b1110, 4'b1100, 4'b1001};
        go(16'd2, 16'd2, 8'd0);
        repeat (6) tick();
        n_vec++;
        if ({state_o, busy, state_chg, done, periods_done} !== {4'b1110, 8'd1}) begin
            n_bad++;
            $display("FAIL reset_mid_pre: got %b/%0d expected 1110/1", {state_o, busy, state_chg, done}, periods_done);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if ({state_o, busy, state_chg, done, periods_done} !== {4'b1000, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_mid_idle: got %b/%0d expected 1000/0", {state_o, busy, state_chg, done}, periods_done);
        end
        go(16'd1, 16'd2, 8'd1);
        for (int c = 1; c <= 4; c++) begin
            n_vec++;
            if ({state_o, busy, state_chg, done} !== e[c-1]) begin
                n_bad++;
                $display("FAIL reset_mid_restart cycle %0d: got %b expected %b", c, {state_o, busy, state_chg, done}, e[c-1]);
            end
            if (c < 4) tick();
        end
        n_vec++;
        if (periods_done !== 8'd1) begin
            n_bad++;
            $display("FAIL reset_mid_count: got %0d expected 1", periods_done);
        end
    endtask

    initial begin
        test_reset();
        test_two_periods();
        test_zero_len();
        test_infinite();
        test_start_ignored();
        test_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
